// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter sequencing one registered DMEM access per granted request
// IDLE grants, ACCESS drives DMEM, RESP returns data to the granted port.
module dmem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [1:0]  req0_size,
    input  logic        req0_sext,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [1:0]  req1_size,
    input  logic        req1_sext,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        dmem_sign_extend,
    output logic [1:0]  dmem_size,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state_q, state_d;
    logic        last_q, last_d, gnt_q, gnt_d, err_q, err_d;
    logic        rd_q, rd_d, wr_q, wr_d, sext_q, sext_d;
    logic [1:0]  size_q, size_d, rsp_v_q, rsp_v_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        pick1, take, sel_we, sel_sext, sel_err;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata;
    // last_q=0 means port 0 won last, so port 1 takes the next conflict
    assign pick1 = req1_valid & (~req0_valid | (FIXED_PRIO == 1'b0 && !last_q));
    assign take = (state_q == IDLE) & ~rst & (req0_valid | req1_valid);
    assign req0_ready = take & ~pick1;
    assign req1_ready = take & pick1;
    assign sel_we = pick1 ? req1_we : req0_we;
    assign sel_sext = pick1 ? req1_sext : req0_sext;
    assign sel_size = pick1 ? req1_size : req0_size;
    assign sel_addr = pick1 ? req1_addr : req0_addr;
    assign sel_wdata = pick1 ? req1_wdata : req0_wdata;
    assign sel_err = (sel_size == 2'b11) | (sel_size == 2'b01 & sel_addr[0]) |
                     (sel_size == 2'b10 & |sel_addr[1:0]);
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        gnt_d = gnt_q;
        err_d = err_q;
        rd_d = 1'b0;
        wr_d = 1'b0;
        sext_d = 1'b0;
        size_d = 2'b00;
        addr_d = '0;
        wdata_d = '0;
        rsp_v_d = 2'b00;
        rsp_rdata_d = '0;
        rsp_err_d = 1'b0;
        case (state_q)
            IDLE: if (take) begin
                state_d = ACCESS;
                last_d = pick1;
                gnt_d = pick1;
                err_d = sel_err;
                rd_d = ~sel_err & ~sel_we;
                wr_d = ~sel_err & sel_we;
                sext_d = sel_sext;
                size_d = sel_size;
                addr_d = sel_addr;
                wdata_d = sel_wdata;
            end
            ACCESS: begin
                state_d = RESP;
                rsp_v_d = gnt_q ? 2'b10 : 2'b01;
                rsp_rdata_d = rd_q ? dmem_rdata : '0;
                rsp_err_d = err_q;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q <= 1'b1;
            gnt_q <= 1'b0;
            err_q <= 1'b0;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            sext_q <= 1'b0;
            size_q <= 2'b00;
            addr_q <= '0;
            wdata_q <= '0;
            rsp_v_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            gnt_q <= gnt_d;
            err_q <= err_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            sext_q <= sext_d;
            size_q <= size_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rsp_v_q <= rsp_v_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign dmem_read = rd_q;
    assign dmem_write = wr_q;
    assign dmem_sign_extend = sext_q;
    assign dmem_size = size_q;
    assign dmem_addr = addr_q;
    assign dmem_wdata = wdata_q;
    assign rsp0_valid = rsp_v_q[0];
    assign rsp1_valid = rsp_v_q[1];
    assign rsp0_rdata = rsp_v_q[0] ? rsp_rdata_q : '0;
    assign rsp1_rdata = rsp_v_q[1] ? rsp_rdata_q : '0;
    assign rsp0_err = rsp_v_q[0] & rsp_err_q;
    assign rsp1_err = rsp_v_q[1] & rsp_err_q;
endmodule
